// File: rtl/qerr_pkg.sv
// Shared constants and state encoding for the requantization error meter.
package qerr_pkg;
  localparam int DW_DEF     = 18;
  localparam int MAXLOG_DEF = 10;
  localparam int ACCW_DEF   = 2 * DW_DEF + MAXLOG_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SQUARE,
    ST_ACC,
    ST_DONE
  } state_t;

  function automatic int acc_width(input int dw, input int maxlog);
    return 2 * dw + maxlog;
  endfunction
endpackage

// File: rtl/qerr_meter_if.sv
// Sample, control and result signals of the error meter, with bench-side and meter-side views.
interface qerr_meter_if import qerr_pkg::*; #(
  parameter int DW = DW_DEF
);
  logic [DW-1:0]   datain;
  logic [DW-1:0]   dataq;
  logic            endata;
  logic [3:0]      Nlog;
  logic            start;
  logic            busy;
  logic            done;
  logic [2*DW-1:0] mse;
  logic            overrun;
  logic [DW-1:0]   peak;

  modport master (
    output datain, dataq, endata, Nlog, start,
    input  busy, done, mse, overrun, peak
  );

  modport slave (
    input  datain, dataq, endata, Nlog, start,
    output busy, done, mse, overrun, peak
  );
endinterface

// File: rtl/seq_square.sv
// Shift-add squarer: one multiplier bit per cycle, DW cycles per product.
module seq_square import qerr_pkg::*; #(
  parameter int DW = DW_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [DW-1:0]   operand,
  output logic            busy,
  output logic [2*DW-1:0] product
);
  localparam int CW = $clog2(DW + 1);

  logic [2*DW-1:0] r_mcand;
  logic [DW-1:0]   r_mplier;
  logic [CW-1:0]   r_cnt;
  logic [2*DW-1:0] r_prod;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_prod   <= '0;
    end else if (start) begin
      r_mcand  <= (2*DW)'(operand);
      r_mplier <= operand;
      r_cnt    <= CW'(DW);
      r_prod   <= '0;
    end else if (r_cnt != '0) begin
      if (r_mplier[0]) r_prod <= r_prod + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
    end
  end

  // busy drops during the final bit so the product is settled on the following cycle
  assign busy    = (r_cnt > CW'(1));
  assign product = r_prod;
endmodule

// File: rtl/qerr_meter.sv
// Windowed mean-squared requantization error meter; peak |error| tracking
// is built only when QERR_PEAK_EN is defined (otherwise peak reads 0).
module qerr_meter import qerr_pkg::*; #(
  parameter int DW     = DW_DEF,
  parameter int MAXLOG = MAXLOG_DEF
) (
  input logic         clock,
  input logic         reset,
  qerr_meter_if.slave bus
);
  // state  | meaning
  // IDLE   | no window open, waiting for start
  // WAIT   | window open, waiting for the next endata pair
  // SQUARE | squaring the latched |error|
  // ACC    | accumulate product, advance sample count
  // DONE   | publish mse/peak, pulse done
  localparam int ACCW = acc_width(DW, MAXLOG);
  localparam int CW   = MAXLOG + 1;
  localparam logic [3:0] MAXLOG4 = 4'(MAXLOG);

  state_t          r_state, w_next;
  logic [3:0]      r_nlog;
  logic [ACCW-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_busy, r_done, r_overrun;
  logic [2*DW-1:0] r_mse;

  logic [DW:0]     w_err, w_mag;
  logic [DW-1:0]   w_abs;
  logic [3:0]      w_nlog_clamp;
  logic [CW-1:0]   w_cnt_inc, w_target;
  logic            w_sq_start, w_sq_busy;
  logic [2*DW-1:0] w_sq_prod;

  assign w_err        = {bus.datain[DW-1], bus.datain} - {bus.dataq[DW-1], bus.dataq};
  assign w_mag        = w_err[DW] ? (~w_err + (DW+1)'(1)) : w_err;
  assign w_abs        = w_mag[DW] ? '1 : w_mag[DW-1:0];
  assign w_nlog_clamp = (bus.Nlog > MAXLOG4) ? MAXLOG4 : bus.Nlog;
  assign w_cnt_inc    = r_cnt + CW'(1);
  assign w_target     = CW'(1) << r_nlog;

  seq_square #(.DW(DW)) u_square (
    .clock   (clock),
    .reset   (reset),
    .start   (w_sq_start),
    .operand (w_abs),
    .busy    (w_sq_busy),
    .product (w_sq_prod)
  );

  always_comb begin
    w_next     = r_state;
    w_sq_start = 1'b0;
    case (r_state)
      ST_IDLE:   if (bus.start) w_next = ST_WAIT;
      ST_WAIT:   if (bus.endata) begin
                   w_next     = ST_SQUARE;
                   w_sq_start = 1'b1;
                 end
      ST_SQUARE: if (!w_sq_busy) w_next = ST_ACC;
      ST_ACC:    w_next = (w_cnt_inc == w_target) ? ST_DONE : ST_WAIT;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_nlog    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_mse     <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: if (bus.start) begin
                   r_nlog    <= w_nlog_clamp;
                   r_acc     <= '0;
                   r_cnt     <= '0;
                   r_overrun <= 1'b0;
                   r_busy    <= 1'b1;
                 end
        ST_ACC:  begin
                   r_acc <= r_acc + ACCW'(w_sq_prod);
                   r_cnt <= w_cnt_inc;
                 end
        ST_DONE: begin
                   r_mse  <= (2*DW)'(r_acc >> r_nlog);
                   r_done <= 1'b1;
                   r_busy <= 1'b0;
                 end
        default: ;
      endcase
      // a start in IDLE sees r_busy low, so a coincident endata never flags
      if (bus.endata && (r_state != ST_WAIT) && r_busy) r_overrun <= 1'b1;
    end
  end

`ifdef QERR_PEAK_EN
  logic [DW-1:0] r_abs, r_peak_run, r_peak;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_abs      <= '0;
      r_peak_run <= '0;
      r_peak     <= '0;
    end else begin
      if ((r_state == ST_IDLE) && bus.start) r_peak_run <= '0;
      if (w_sq_start) r_abs <= w_abs;
      if ((r_state == ST_ACC) && (r_abs > r_peak_run)) r_peak_run <= r_abs;
      if (r_state == ST_DONE) r_peak <= r_peak_run;
    end
  end

  assign bus.peak = r_peak;
`else
  assign bus.peak = '0;
`endif

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.mse     = r_mse;
  assign bus.overrun = r_overrun;
endmodule
